// File: rtl/parity_tx_pkg.sv
// Shared definitions for the parity framing transmitter: frame geometry,
// line levels and the transmitter state encoding.
package parity_tx_pkg;

  localparam int   FRAME_BITS  = 7;
  localparam int   DATA_BITS   = 4;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/parity_encoder.sv
// 4-bit combinational even-parity generator.
// Ports:
//   data   - input word
//   parity - XOR of all data bits; data plus parity carry an even count of 1s
module parity_encoder
  import parity_tx_pkg::*;
(
  input  logic [DATA_BITS-1:0] data,
  output logic                 parity
);

  assign parity = ^data;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial framing stage: accepts a 4-bit word over valid/ready and sends it
// as start(0), d0..d3, even parity, stop(1); each bit lasts CLKS_PER_BIT clocks.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   data_in     - word to send, latched on handshake
//   in_valid    - data_in valid
//   in_ready    - block idle and not in reset; a word may be accepted
//   tx_serial   - registered serial line, idles high
//   busy        - frame in progress
//   frame_done  - one-cycle pulse in the first idle cycle after a stop bit
module parity_frame_tx
  import parity_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx_serial,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]       IDX_LAST = 2'(DATA_BITS - 1);

  tx_state_t              state, state_n;
  logic [CNT_W-1:0]       clk_cnt, cnt_n;
  logic [1:0]             bit_idx, idx_n;
  logic [DATA_BITS-1:0]   data_hold;
  logic                   par;
  logic                   tx_n;
  logic                   done_n;
  logic                   accept;
  logic                   bit_end;

  parity_encoder u_parity (
    .data   (data_hold),
    .parity (par)
  );

  assign accept  = in_valid && in_ready;
  assign bit_end = (clk_cnt == CNT_LAST);

  // State register; tx_serial is loaded with the level of the state being
  // entered so the line changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      tx_serial  <= IDLE_LEVEL;
      frame_done <= 1'b0;
      data_hold  <= '0;
    end else begin
      state      <= state_n;
      clk_cnt    <= cnt_n;
      bit_idx    <= idx_n;
      tx_serial  <= tx_n;
      frame_done <= done_n;
      if (accept) data_hold <= data_in;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_n = state;
    cnt_n   = clk_cnt;
    idx_n   = bit_idx;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == IDX_LAST) state_n = PARITY;
          else                     idx_n   = bit_idx + 2'd1;
        end else begin
          cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          cnt_n   = '0;
        end else begin
          cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  // Outputs and the line level for the upcoming state.
  always_comb begin
    in_ready = (state == IDLE) && !rst;
    busy     = (state != IDLE);
    tx_n     = IDLE_LEVEL;
    unique case (state_n)
      IDLE:    tx_n = IDLE_LEVEL;
      START:   tx_n = START_LEVEL;
      DATA:    tx_n = data_hold[idx_n];
      PARITY:  tx_n = par;
      STOP:    tx_n = STOP_LEVEL;
      default: tx_n = IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: one instance at 4 clocks/bit and
// one at 1 clock/bit, checked cycle by cycle against a frame model.
module tb_parity_frame_tx;

  localparam int CA = 4;
  localparam int CB = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.CLKS_PER_BIT(CA)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_a), .in_valid(valid_a),
    .in_ready(ready_a), .tx_serial(tx_a), .busy(busy_a), .frame_done(done_a)
  );

  parity_frame_tx #(.CLKS_PER_BIT(CB)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_b), .in_valid(valid_b),
    .in_ready(ready_b), .tx_serial(tx_b), .busy(busy_b), .frame_done(done_b)
  );

  // Expected line levels of one frame, index = bit slot in time order.
  function automatic logic [6:0] frame_bits(input logic [3:0] d);
    int unsigned ones = 0;
    logic [6:0]  f;
    for (int i = 0; i < 4; i++) ones += d[i];
    f[0]   = 1'b0;
    f[4:1] = d;
    f[5]   = (ones % 2) != 0;
    f[6]   = 1'b1;
    return f;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input bit sel, input string tag, input logic tx,
                           input logic bz, input logic dn, input logic rd);
    string p;
    p = sel ? "B" : "A";
    check($sformatf("%s %s tx", p, tag),    sel ? tx_b    : tx_a,    tx);
    check($sformatf("%s %s busy", p, tag),  sel ? busy_b  : busy_a,  bz);
    check($sformatf("%s %s done", p, tag),  sel ? done_b  : done_a,  dn);
    check($sformatf("%s %s ready", p, tag), sel ? ready_b : ready_a, rd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [3:0] d);
    if (sel) begin valid_b = v; data_b = d; end
    else     begin valid_a = v; data_a = d; end
  endtask

  // Sends d starting from an idle cycle. hold keeps in_valid high through
  // the frame with junk data, presenting next_d for the first idle cycle.
  // bp pulses in_valid for one cycle mid-frame.
  task automatic frame(input bit sel, input logic [3:0] d, input bit hold,
                       input logic [3:0] next_d, input bit bp);
    int         cpb;
    logic [6:0] fb;
    cpb = sel ? CB : CA;
    fb  = frame_bits(d);
    drive(sel, 1'b1, d);
    check(sel ? "B pre ready" : "A pre ready", sel ? ready_b : ready_a, 1'b1);
    step();
    drive(sel, hold, 4'($urandom));
    for (int j = 0; j < 7 * cpb; j++) begin
      check_out(sel, $sformatf("d=%h cyc%0d", d, j), fb[j / cpb], 1'b1, 1'b0, 1'b0);
      if (hold)                         drive(sel, 1'b1, (j == 7 * cpb - 1) ? next_d : 4'($urandom));
      else if (bp && (j == 3 * cpb))    drive(sel, 1'b1, 4'($urandom));
      else                              drive(sel, 1'b0, 4'($urandom));
      step();
    end
    check_out(sel, $sformatf("d=%h end", d), 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_out(sel, "idle", 1'b1, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cur, nxt, rd;
    logic [6:0] fb;
    bit         hold;

    // Reset with in_valid high: reset wins.
    rst = 1'b1;
    drive(0, 1'b1, 4'($urandom));
    drive(1, 1'b1, 4'($urandom));
    step();
    step();
    check_out(0, "reset", 1'b1, 1'b0, 1'b0, 1'b0);
    check_out(1, "reset", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    step();
    check_out(0, "post reset", 1'b1, 1'b0, 1'b0, 1'b1);
    check_out(1, "post reset", 1'b1, 1'b0, 1'b0, 1'b1);

    // Directed frames on the 4-clock instance.
    frame(0, 4'b1011, 1'b0, '0, 1'b0);
    idle(0, 2);
    frame(0, 4'b0000, 1'b0, '0, 1'b0);
    idle(0, 1);
    frame(0, 4'b0111, 1'b0, '0, 1'b0);
    idle(0, 1);

    // Back-to-back with in_valid held and data toggling mid-frame.
    frame(0, 4'b0101, 1'b1, 4'b1100, 1'b0);
    frame(0, 4'b1100, 1'b0, '0, 1'b0);
    idle(0, 1);

    // Backpressure: a one-cycle valid pulse while busy is dropped.
    frame(0, 4'b0110, 1'b0, '0, 1'b1);
    idle(0, 3);

    // Reset during DATA bit 2, with in_valid high during the reset.
    rd = 4'($urandom);
    fb = frame_bits(rd);
    drive(0, 1'b1, rd);
    step();
    drive(0, 1'b0, 4'($urandom));
    for (int j = 0; j < 3 * CA + 1; j++) begin
      check_out(0, $sformatf("pre-rst cyc%0d", j), fb[j / CA], 1'b1, 1'b0, 1'b0);
      step();
    end
    rst = 1'b1;
    drive(0, 1'b1, 4'($urandom));
    step();
    check_out(0, "mid rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check_out(1, "mid rst", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(0, 1'b0, '0);
    step();
    check_out(0, "after rst", 1'b1, 1'b0, 1'b0, 1'b1);
    frame(0, 4'b1111, 1'b0, '0, 1'b0);
    idle(0, 1);

    // One clock per bit.
    frame(1, 4'b1000, 1'b0, '0, 1'b0);
    idle(1, 1);
    frame(1, 4'b0011, 1'b1, 4'b1110, 1'b0);
    frame(1, 4'b1110, 1'b0, '0, 1'b1);
    idle(1, 2);

    // Randomized traffic on both instances.
    for (int s = 0; s < 2; s++) begin
      cur = 4'($urandom);
      for (int k = 0; k < 12; k++) begin
        hold = (k < 11) ? bit'($urandom_range(0, 1)) : 1'b0;
        nxt  = 4'($urandom);
        frame(s[0], cur, hold, nxt, !hold && bit'($urandom_range(0, 1)));
        if (!hold) idle(s[0], $urandom_range(0, 2));
        cur = hold ? nxt : 4'($urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
